// File: rtl/mor1kx_fetch_queue_if.sv
// Fetch-queue handshake bundle: ibus request/response, redirect sources and the decode-side entry.
// master = fetch queue, slave = ibus/decode environment.
`ifndef OR1K_INSN_WIDTH
`define OR1K_INSN_WIDTH 32
`endif

interface mor1kx_fetch_queue_if #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int FIFO_DEPTH           = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                            ibus_req_o;
  logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_o;
  logic                            ibus_ack_i;
  logic                            ibus_err_i;
  logic [`OR1K_INSN_WIDTH-1:0]     ibus_dat_i;
  logic                            redirect_i;
  logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_i;
  logic                            du_restart_i;
  logic [OPTION_OPERAND_WIDTH-1:0] du_restart_pc_i;
  logic                            pipeline_flush_i;
  logic                            decode_ready_i;
  logic                            decode_valid_o;
  logic [`OR1K_INSN_WIDTH-1:0]     decode_insn_o;
  logic [OPTION_OPERAND_WIDTH-1:0] pc_decode_o;
  logic                            decode_except_ibus_err_o;
  logic [LW-1:0]                   fifo_level_o;

  modport master (
    output ibus_req_o, ibus_adr_o, decode_valid_o, decode_insn_o, pc_decode_o,
           decode_except_ibus_err_o, fifo_level_o,
    input  ibus_ack_i, ibus_err_i, ibus_dat_i, redirect_i, redirect_pc_i, du_restart_i,
           du_restart_pc_i, pipeline_flush_i, decode_ready_i
  );

  modport slave (
    input  ibus_req_o, ibus_adr_o, decode_valid_o, decode_insn_o, pc_decode_o,
           decode_except_ibus_err_o, fifo_level_o,
    output ibus_ack_i, ibus_err_i, ibus_dat_i, redirect_i, redirect_pc_i, du_restart_i,
           du_restart_pc_i, pipeline_flush_i, decode_ready_i
  );
endinterface

// File: rtl/mor1kx_fetch_queue.sv
// Prefetch FIFO fetch stage between ibus and decode, with redirect/flush discard handling.
// MOR1KX_FETCH_BYPASS_EN: present an ack combinationally to decode when the queue is empty.
`ifndef OR1K_INSN_WIDTH
`define OR1K_INSN_WIDTH 32
`endif
`ifndef OR1K_RESET_VECTOR
`define OR1K_RESET_VECTOR 5'h01
`endif
`ifndef OR1K_OPCODE_NOP
`define OR1K_OPCODE_NOP 6'h05
`endif

module mor1kx_fetch_queue #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter logic [OPTION_OPERAND_WIDTH-1:0] OPTION_RESET_PC =
    {{(OPTION_OPERAND_WIDTH-13){1'b0}}, `OR1K_RESET_VECTOR, 8'd0},
  parameter int FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  mor1kx_fetch_queue_if.master bus
);
  localparam int AW = OPTION_OPERAND_WIDTH;
  localparam int IW = `OR1K_INSN_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [IW-1:0] NOP_INSN = {`OR1K_OPCODE_NOP, 26'd0};

  typedef enum logic [1:0] {FETCH, DISCARD, HALT} state_t;

  state_t        state;
  logic          req;
  logic [AW-1:0] adr;
  logic [AW-1:0] pend_pc;
  logic          pend_halt;
  logic [IW-1:0] q_insn [FIFO_DEPTH];
  logic [AW-1:0] q_pc   [FIFO_DEPTH];
  logic          q_err  [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count, count_nxt;

  logic          done_ack, done_err, done, restart, clear, fetch_done;
  logic          bypass, push, pop;
  logic [AW-1:0] target;

  assign done_err   = req & bus.ibus_err_i;
  assign done_ack   = req & bus.ibus_ack_i & ~bus.ibus_err_i;
  assign done       = done_ack | done_err;
  assign restart    = bus.du_restart_i | bus.redirect_i;
  assign clear      = restart | bus.pipeline_flush_i;
  assign target     = bus.du_restart_i ? bus.du_restart_pc_i : bus.redirect_pc_i;
  assign fetch_done = (state == FETCH) & done & ~clear;

`ifdef MOR1KX_FETCH_BYPASS_EN
  assign bypass = (count == '0) & done_ack & (state == FETCH) & ~clear;
`else
  assign bypass = 1'b0;
`endif

  assign bus.decode_valid_o           = (count != '0) | bypass;
  assign bus.decode_insn_o            = bypass ? bus.ibus_dat_i : q_insn[rd_ptr];
  assign bus.pc_decode_o              = bypass ? adr : q_pc[rd_ptr];
  assign bus.decode_except_ibus_err_o = bypass ? 1'b0 : q_err[rd_ptr];
  assign bus.fifo_level_o             = count;
  assign bus.ibus_req_o               = req;
  assign bus.ibus_adr_o               = adr;

  // A bypassed entry taken by decode in the same cycle never occupies a slot.
  assign push      = fetch_done & ~(bypass & bus.decode_ready_i);
  assign pop       = (count != '0) & bus.decode_ready_i;
  assign count_nxt = clear ? '0 : count + LW'(push) - LW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      req       <= 1'b0;
      adr       <= OPTION_RESET_PC;
      pend_pc   <= OPTION_RESET_PC;
      pend_halt <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        q_insn[i] <= '0;
        q_pc[i]   <= OPTION_RESET_PC;
        q_err[i]  <= 1'b0;
      end
    end else begin
      count <= count_nxt;
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          q_insn[wr_ptr] <= done_err ? NOP_INSN : bus.ibus_dat_i;
          q_pc[wr_ptr]   <= adr;
          q_err[wr_ptr]  <= done_err;
          wr_ptr         <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
      end

      // An unfinished request must be drained before the new target can be issued.
      if (clear) begin
        if (req && !done) begin
          state     <= DISCARD;
          pend_pc   <= target;
          pend_halt <= ~restart;
        end else if (restart) begin
          state <= FETCH;
          adr   <= target;
          req   <= 1'b1;
        end else begin
          state <= HALT;
          req   <= 1'b0;
        end
      end else begin
        case (state)
          FETCH: begin
            if (done_err) begin
              state <= HALT;
              req   <= 1'b0;
            end else if (done_ack) begin
              adr <= adr + AW'(4);
              req <= (count_nxt < DEPTH_L);
            end else if (!req) begin
              req <= (count_nxt < DEPTH_L);
            end
          end
          DISCARD: begin
            if (done) begin
              if (pend_halt) begin
                state <= HALT;
                req   <= 1'b0;
              end else begin
                state <= FETCH;
                adr   <= pend_pc;
                req   <= 1'b1;
              end
            end
          end
          default: req <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mor1kx_fetch_queue.sv
// Randomized bench for mor1kx_fetch_queue against a queue-based model of the fetch/decode stream.
module tb_mor1kx_fetch_queue;
  localparam int          AW       = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] NOP_INSN = 32'h1400_0000;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
    logic        err;
  } entry_t;

  typedef enum {M_RUN, M_DRAIN, M_STOP} mode_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mor1kx_fetch_queue_if #(.OPTION_OPERAND_WIDTH(AW), .FIFO_DEPTH(DEPTH)) bus ();

  mor1kx_fetch_queue #(.OPTION_OPERAND_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  entry_t      m_q[$];
  mode_t       m_mode;
  logic        m_req;
  logic [31:0] m_adr;
  logic [31:0] m_pend;
  logic        m_pend_stop;

  bit armed;
  int wcnt;
  int lat_max, p_ready, p_redir, p_restart, p_flush, p_err, p_stray;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_mode      = M_RUN;
    m_req       = 1'b0;
    m_adr       = RESET_PC;
    m_pend      = RESET_PC;
    m_pend_stop = 1'b0;
    armed       = 1'b0;
  endtask

  task automatic drive_idle();
    bus.ibus_ack_i       = 1'b0;
    bus.ibus_err_i       = 1'b0;
    bus.ibus_dat_i       = '0;
    bus.redirect_i       = 1'b0;
    bus.redirect_pc_i    = '0;
    bus.du_restart_i     = 1'b0;
    bus.du_restart_pc_i  = '0;
    bus.pipeline_flush_i = 1'b0;
    bus.decode_ready_i   = 1'b0;
  endtask

  task automatic check_reset_values();
    chk("rst_req",   bus.ibus_req_o, 0);
    chk("rst_adr",   bus.ibus_adr_o, RESET_PC);
    chk("rst_valid", bus.decode_valid_o, 0);
    chk("rst_insn",  bus.decode_insn_o, 0);
    chk("rst_pc",    bus.pc_decode_o, RESET_PC);
    chk("rst_err",   bus.decode_except_ibus_err_o, 0);
    chk("rst_level", bus.fifo_level_o, 0);
  endtask

  task automatic compare();
    chk("req", bus.ibus_req_o, m_req);
    if (m_req) chk("adr", bus.ibus_adr_o, m_adr);
    chk("valid", bus.decode_valid_o, m_q.size() != 0);
    chk("level", bus.fifo_level_o, m_q.size());
    if (m_q.size() != 0) begin
      chk("head_pc",   bus.pc_decode_o, m_q[0].pc);
      chk("head_insn", bus.decode_insn_o, m_q[0].insn);
      chk("head_err",  bus.decode_except_ibus_err_o, m_q[0].err);
    end
  endtask

  // Predicts the stream state after the coming clock edge from the inputs just driven.
  task automatic model_step(input logic ack, input logic err, input logic redir, input logic du,
                            input logic flush, input logic ready,
                            input logic [31:0] rpc, input logic [31:0] dpc);
    logic   done, restart, held;
    entry_t e;
    done    = m_req && (ack || err);
    restart = redir || du;
    held    = m_req && !done;

    if (restart || flush) begin
      m_q.delete();
    end else begin
      if (m_q.size() != 0 && ready) void'(m_q.pop_front());
      if (m_mode == M_RUN && done) begin
        e.pc   = m_adr;
        e.err  = err;
        e.insn = err ? NOP_INSN : insn_of(m_adr);
        m_q.push_back(e);
      end
    end

    if (restart || flush) begin
      if (held) begin
        m_mode      = M_DRAIN;
        m_pend_stop = !restart;
        if (restart) m_pend = du ? dpc : rpc;
      end else if (restart) begin
        m_mode = M_RUN;
        m_adr  = du ? dpc : rpc;
      end else begin
        m_mode = M_STOP;
      end
    end else if (done) begin
      if (m_mode == M_RUN) begin
        if (err) m_mode = M_STOP;
        else     m_adr  = m_adr + 32'd4;
      end else if (m_mode == M_DRAIN) begin
        if (m_pend_stop) m_mode = M_STOP;
        else begin
          m_mode = M_RUN;
          m_adr  = m_pend;
        end
      end
    end

    case (m_mode)
      M_DRAIN: m_req = 1'b1;
      M_RUN:   m_req = held || (m_q.size() < DEPTH);
      default: m_req = 1'b0;
    endcase
  endtask

  task automatic cycle();
    logic        ack, err, redir, du, flush, ready;
    logic [31:0] rpc, dpc;
    compare();
    ack = 1'b0;
    err = 1'b0;
    if (bus.ibus_req_o) begin
      if (!armed) begin
        armed = 1'b1;
        wcnt  = $urandom_range(0, lat_max);
      end
      if (wcnt == 0) begin
        armed = 1'b0;
        if (pct(p_err)) err = 1'b1;
        else            ack = 1'b1;
      end else begin
        wcnt--;
      end
    end else begin
      armed = 1'b0;
      ack   = pct(p_stray);
    end
    redir = pct(p_redir);
    du    = pct(p_restart);
    flush = pct(p_flush);
    ready = pct(p_ready);
    rpc   = $urandom & 32'h0000_fffc;
    dpc   = $urandom & 32'h0000_fffc;

    bus.ibus_ack_i       = ack;
    bus.ibus_err_i       = err;
    bus.ibus_dat_i       = insn_of(bus.ibus_adr_o);
    bus.redirect_i       = redir;
    bus.redirect_pc_i    = rpc;
    bus.du_restart_i     = du;
    bus.du_restart_pc_i  = dpc;
    bus.pipeline_flush_i = flush;
    bus.decode_ready_i   = ready;
    model_step(ack, err, redir, du, flush, ready, rpc, dpc);
  endtask

  task automatic set_knobs(input int lat, input int rdy, input int rdr, input int rst,
                           input int fl, input int er, input int st);
    lat_max = lat; p_ready = rdy; p_redir = rdr; p_restart = rst;
    p_flush = fl; p_err = er; p_stray = st;
  endtask

  initial begin
    drive_idle();
    model_reset();
    set_knobs(0, 100, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1 check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Streaming with an ack every cycle and decode always ready.
    repeat (20) begin @(negedge clk); cycle(); end

    // Decode stalled: queue fills, then a single pop reopens one slot.
    set_knobs(0, 0, 0, 0, 0, 0, 0);
    repeat (12) begin @(negedge clk); cycle(); end
    p_ready = 100;
    @(negedge clk); cycle();
    p_ready = 0;
    repeat (4) begin @(negedge clk); cycle(); end

    // Restart and redirect together: restart target must win.
    set_knobs(0, 50, 100, 100, 0, 0, 0);
    repeat (3) begin @(negedge clk); cycle(); end

    set_knobs(3, 60, 4, 2, 2, 3, 5);
    repeat (1500) begin @(negedge clk); cycle(); end

    // Asynchronous reset with three entries queued.
    set_knobs(1, 0, 0, 100, 0, 0, 0);
    @(negedge clk); cycle();
    p_restart = 0;
    for (int i = 0; i < 40 && m_q.size() < 3; i++) begin
      @(negedge clk); cycle();
    end
    @(negedge clk);
    compare();
    chk("fill_to_3", bus.fifo_level_o, 3);
    rst_n = 1'b0;
    drive_idle();
    #1 check_reset_values();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    set_knobs(2, 70, 3, 2, 2, 2, 5);
    repeat (300) begin @(negedge clk); cycle(); end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
